multicycle_main_control: RTL and testbench

//  Multi-cycle main control FSM. Decodes the instruction opcode, sequences fetch/decode/execute/memory/writeback,
//  and drives datapath enables plus the 3-bit ALUop consumed by the downstream ALU control stage.

---
 rtl/mips_ctrl_pkg.sv | 40 ++++
 rtl/mmc_output_decode.sv | 109 ++++++++++
 rtl/multicycle_main_control.sv | 130 +++++++++++++
 tb/tb_multicycle_main_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, ALUop and state encodings shared by the main control and ALU control stages
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [2:0] ALUOP_RTYPE = 3'b111;
   localparam logic [2:0] ALUOP_ADD   = 3'b101;
   localparam logic [2:0] ALUOP_SUB   = 3'b110;
   localparam logic [2:0] ALUOP_AND   = 3'b000;
   localparam logic [2:0] ALUOP_OR    = 3'b001;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_MEMADDR = 4'd3,
      ST_MEMRD   = 4'd4,
      ST_MEMWB   = 4'd5,
      ST_MEMWR   = 4'd6,
      ST_R_EX    = 4'd7,
      ST_R_WB    = 4'd8,
      ST_I_EX    = 4'd9,
      ST_I_WB    = 4'd10,
      ST_BRANCH  = 4'd11,
      ST_ERROR   = 4'd12,
      ST_TRAP    = 4'd13
   } state_e;

   // States that wait on mem_ready and are therefore covered by the timeout counter.
   function automatic logic is_mem_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/mmc_output_decode.sv
// rtl/mmc_output_decode.sv - combinational state/opcode/mem_ready to datapath control decode
// Optional MMC_ILLEGAL_TRAP_EN adds illegal_op_o, raised only in the TRAP state.
module mmc_output_decode
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_we_o,
   output logic       iord_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic [1:0] pc_src_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o
`ifdef MMC_ILLEGAL_TRAP_EN
   ,
   output logic       illegal_op_o
`endif
);

   always_comb begin
      mem_req_o       = 1'b0;
      mem_we_o        = 1'b0;
      iord_o          = 1'b0;
      ir_write_o      = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_src_o        = 2'b00;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = ALUOP_ADD;
      reg_write_o     = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
`ifdef MMC_ILLEGAL_TRAP_EN
      illegal_op_o    = 1'b0;
`endif
      unique case (state_e'(state_i))
         ST_FETCH: begin
            // IR and PC load on the completing beat only, so a stalled fetch leaves both untouched.
            mem_req_o   = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         ST_DECODE: begin
            alu_src_b_o = 2'b11;
         end
         ST_MEMADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
         end
         ST_MEMRD: begin
            mem_req_o = 1'b1;
            iord_o    = 1'b1;
         end
         ST_MEMWB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         ST_MEMWR: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            iord_o    = 1'b1;
         end
         ST_R_EX: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_RTYPE;
         end
         ST_R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
         end
         ST_I_EX: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            case (opcode_i)
               OP_ANDI: alu_op_o = ALUOP_AND;
               OP_ORI:  alu_op_o = ALUOP_OR;
               default: alu_op_o = ALUOP_ADD;
            endcase
         end
         ST_I_WB: begin
            reg_write_o = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = ALUOP_SUB;
            pc_write_cond_o = 1'b1;
            pc_src_o        = 2'b01;
         end
`ifdef MMC_ILLEGAL_TRAP_EN
         ST_TRAP: begin
            illegal_op_o = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multi-cycle main control FSM with memory wait timeout and sticky bus error
// Optional MMC_ILLEGAL_TRAP_EN: unknown opcodes trap and raise illegal_op instead of acting as a NOP.
module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       bus_err,
`ifdef MMC_ILLEGAL_TRAP_EN
   output logic       illegal_op,
`endif
   output logic [3:0] state_o
);

   state_e            state_q, state_d;
   logic [TO_W-1:0]   wait_q, wait_d;
   logic              bus_err_q, bus_err_d;
   logic              mem_wait;
   logic              timeout_hit;

   assign mem_wait    = is_mem_state(state_q) && !mem_ready;
   // A completing access in the last allowed cycle is not a timeout: mem_wait already requires mem_ready=0.
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == TO_W'(MEM_TIMEOUT));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)        state_d = ST_DECODE;
            else if (timeout_hit) state_d = ST_ERROR;
         end
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:                  state_d = ST_R_EX;
               OP_LW, OP_SW:              state_d = ST_MEMADDR;
               OP_BEQ:                    state_d = ST_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:  state_d = ST_I_EX;
`ifdef MMC_ILLEGAL_TRAP_EN
               default:                   state_d = ST_TRAP;
`else
               default:                   state_d = ST_FETCH;
`endif
            endcase
         end
         ST_MEMADDR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (mem_ready)        state_d = ST_MEMWB;
            else if (timeout_hit) state_d = ST_ERROR;
         end
         ST_MEMWB: state_d = ST_FETCH;
         ST_MEMWR: begin
            if (mem_ready)        state_d = ST_FETCH;
            else if (timeout_hit) state_d = ST_ERROR;
         end
         ST_R_EX:   state_d = ST_R_WB;
         ST_R_WB:   state_d = ST_FETCH;
         ST_I_EX:   state_d = ST_I_WB;
         ST_I_WB:   state_d = ST_FETCH;
         ST_BRANCH: state_d = ST_FETCH;
         ST_ERROR:  state_d = ST_ERROR;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wait_d    = wait_q;
      bus_err_d = bus_err_q | timeout_hit;
      if (state_d != state_q) wait_d = '0;
      else if (mem_wait)      wait_d = wait_q + TO_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;
   assign state_o = state_q;

   mmc_output_decode u_decode (
      .state_i         (state_q),
      .opcode_i        (opcode),
      .mem_ready_i     (mem_ready),
      .mem_req_o       (mem_req),
      .mem_we_o        (mem_we),
      .iord_o          (iord),
      .ir_write_o      (ir_write),
      .pc_write_o      (pc_write),
      .pc_write_cond_o (pc_write_cond),
      .pc_src_o        (pc_src),
      .alu_src_a_o     (alu_src_a),
      .alu_src_b_o     (alu_src_b),
      .alu_op_o        (alu_op),
      .reg_write_o     (reg_write),
      .reg_dst_o       (reg_dst),
      .mem_to_reg_o    (mem_to_reg)
`ifdef MMC_ILLEGAL_TRAP_EN
      ,
      .illegal_op_o    (illegal_op)
`endif
   );

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_src, alu_src_b;
   logic       alu_src_a;
   logic [2:0] alu_op;
   logic       reg_write, reg_dst, mem_to_reg, bus_err;
   logic [3:0] state_o;
`ifdef MMC_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_main_control dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .bus_err       (bus_err),
`ifdef MMC_ILLEGAL_TRAP_EN
      .illegal_op    (illegal_op),
`endif
      .state_o       (state_o)
   );

   // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_cond}, pc_src, alu_src_a, alu_src_b, alu_op,
   // {reg_write,reg_dst,mem_to_reg,bus_err}
   logic [17:0] ctrl;
   assign ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, bus_err};

   localparam logic [17:0] E_IDLE    = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b0000};
   localparam logic [17:0] E_FETCH1  = {6'b100110, 2'b00, 1'b0, 2'b01, 3'b101, 4'b0000};
   localparam logic [17:0] E_FETCH0  = {6'b100000, 2'b00, 1'b0, 2'b01, 3'b101, 4'b0000};
   localparam logic [17:0] E_DECODE  = {6'b000000, 2'b00, 1'b0, 2'b11, 3'b101, 4'b0000};
   localparam logic [17:0] E_MEMADDR = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b101, 4'b0000};
   localparam logic [17:0] E_MEMRD   = {6'b101000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b0000};
   localparam logic [17:0] E_MEMWB   = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b1010};
   localparam logic [17:0] E_MEMWR   = {6'b111000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b0000};
   localparam logic [17:0] E_REX     = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b111, 4'b0000};
   localparam logic [17:0] E_RWB     = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b1100};
   localparam logic [17:0] E_IEX_OR  = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b001, 4'b0000};
   localparam logic [17:0] E_IEX_AND = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b000, 4'b0000};
   localparam logic [17:0] E_IEX_ADD = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b101, 4'b0000};
   localparam logic [17:0] E_IWB     = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b1000};
   localparam logic [17:0] E_BR      = {6'b000001, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
   localparam logic [17:0] E_ERR     = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b101, 4'b0001};

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_ANDI = 6'b001100;
   localparam logic [5:0] OPC_ORI  = 6'b001101;
   localparam logic [5:0] OPC_BAD  = 6'b111111;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [3:0] st, input logic [17:0] e);
      chk({tag, ".state"}, {28'd0, state_o}, {28'd0, st});
      chk({tag, ".ctrl"}, {14'd0, ctrl}, {14'd0, e});
   endtask

   // Drive inputs for the next cycle after the falling edge, then settle before sampling.
   task automatic cyc(input logic rdy, input logic [5:0] op);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      opcode    = OPC_R;
      @(negedge clk); #1;
      expect_st("reset", 4'd0, E_IDLE);
      @(negedge clk); reset_n = 1'b1; #1;
      expect_st("idle", 4'd0, E_IDLE);

      cyc(1'b1, OPC_R); expect_st("r.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_R); expect_st("r.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_R); expect_st("r.ex", 4'd7, E_REX);
      cyc(1'b1, OPC_R); expect_st("r.wb", 4'd8, E_RWB);
      cyc(1'b0, OPC_R); expect_st("r.fetch5", 4'd1, E_FETCH0);

      cyc(1'b1, OPC_LW); expect_st("lw.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_LW); expect_st("lw.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_LW); expect_st("lw.memaddr", 4'd3, E_MEMADDR);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, OPC_LW); expect_st("lw.memrd_wait", 4'd4, E_MEMRD);
      end
      cyc(1'b1, OPC_LW); expect_st("lw.memrd_done", 4'd4, E_MEMRD);
      cyc(1'b1, OPC_LW); expect_st("lw.memwb", 4'd5, E_MEMWB);

      cyc(1'b1, OPC_SW); expect_st("sw.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_SW); expect_st("sw.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_SW); expect_st("sw.memaddr", 4'd3, E_MEMADDR);
      cyc(1'b1, OPC_SW); expect_st("sw.memwr", 4'd6, E_MEMWR);

      cyc(1'b1, OPC_BEQ); expect_st("beq.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_BEQ); expect_st("beq.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_BEQ); expect_st("beq.branch", 4'd11, E_BR);

      cyc(1'b1, OPC_ORI); expect_st("ori.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_ORI); expect_st("ori.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_ORI); expect_st("ori.iex", 4'd9, E_IEX_OR);
      cyc(1'b1, OPC_ORI); expect_st("ori.iwb", 4'd10, E_IWB);
      cyc(1'b1, OPC_ANDI); expect_st("andi.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_ANDI); expect_st("andi.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_ANDI); expect_st("andi.iex", 4'd9, E_IEX_AND);
      cyc(1'b1, OPC_ANDI); expect_st("andi.iwb", 4'd10, E_IWB);
      cyc(1'b1, OPC_ADDI); expect_st("addi.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_ADDI); expect_st("addi.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_ADDI); expect_st("addi.iex", 4'd9, E_IEX_ADD);
      cyc(1'b1, OPC_ADDI); expect_st("addi.iwb", 4'd10, E_IWB);

      cyc(1'b1, OPC_BAD); expect_st("bad.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_BAD); expect_st("bad.decode", 4'd2, E_DECODE);
`ifdef MMC_ILLEGAL_TRAP_EN
      cyc(1'b1, OPC_BAD); expect_st("bad.trap", 4'd13, E_IDLE);
      chk("bad.illegal_op", {31'd0, illegal_op}, 32'd1);
      cyc(1'b1, OPC_R); expect_st("bad.trap_hold", 4'd13, E_IDLE);
      @(negedge clk); reset_n = 1'b0; #1;
      chk("bad.illegal_op_rst", {31'd0, illegal_op}, 32'd0);
      @(negedge clk); reset_n = 1'b1; #1;
`else
      cyc(1'b0, OPC_BAD); expect_st("bad.nop_fetch", 4'd1, E_FETCH0);
`endif

      cyc(1'b1, OPC_LW); expect_st("rst.fetch", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_LW); expect_st("rst.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_LW); expect_st("rst.memaddr", 4'd3, E_MEMADDR);
      cyc(1'b0, OPC_LW); expect_st("rst.memrd", 4'd4, E_MEMRD);
      reset_n = 1'b0; #1;
      expect_st("rst.async", 4'd0, E_IDLE);
      @(negedge clk); reset_n = 1'b1; #1;
      expect_st("rst.idle", 4'd0, E_IDLE);

      // 15 stalled fetch cycles, then mem_ready arrives exactly at the timeout count.
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, OPC_R); expect_st("win.fetch_wait", 4'd1, E_FETCH0);
      end
      cyc(1'b1, OPC_R); expect_st("win.fetch_done", 4'd1, E_FETCH1);
      cyc(1'b1, OPC_R); expect_st("win.decode", 4'd2, E_DECODE);
      cyc(1'b1, OPC_R); expect_st("win.rex", 4'd7, E_REX);
      cyc(1'b1, OPC_R); expect_st("win.rwb", 4'd8, E_RWB);

      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, OPC_R); expect_st("to.fetch_wait", 4'd1, E_FETCH0);
      end
      cyc(1'b0, OPC_R); expect_st("to.error", 4'd12, E_ERR);
      cyc(1'b1, OPC_R); expect_st("to.error_hold", 4'd12, E_ERR);
      cyc(1'b1, OPC_R); expect_st("to.error_sticky", 4'd12, E_ERR);
      reset_n = 1'b0; #1;
      expect_st("to.reset_clears", 4'd0, E_IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
